// File: rtl/rtype_pkg.sv
// Shared types, opcode constants and the R-type decoder for rtype_exec_ctrl.
// Build option: define RTYPE_MUL_EN to decode MUL (funct7=0x01, funct3=0) as legal.
package rtype_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [6:0] OPC_RTYPE     = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE   = 7'h00;
  localparam logic [6:0] FUNCT7_ALT    = 7'h20;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  localparam logic [2:0] FUNCT3_ADD  = 3'd0;
  localparam logic [2:0] FUNCT3_SLL  = 3'd1;
  localparam logic [2:0] FUNCT3_SLT  = 3'd2;
  localparam logic [2:0] FUNCT3_SLTU = 3'd3;
  localparam logic [2:0] FUNCT3_XOR  = 3'd4;
  localparam logic [2:0] FUNCT3_SR   = 3'd5;
  localparam logic [2:0] FUNCT3_OR   = 3'd6;
  localparam logic [2:0] FUNCT3_AND  = 3'd7;

  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_t;

  typedef struct packed {
    logic    legal;
    alu_op_t op;
  } dec_t;

  // Anything not explicitly matched stays illegal.
  function automatic dec_t rtype_decode(input logic [ILEN-1:0] instr);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7      = instr[31:25];
    f3      = instr[14:12];
    d.legal = 1'b0;
    d.op    = ALU_ADD;
    if (instr[6:0] == OPC_RTYPE) begin
      case (f7)
        FUNCT7_BASE: begin
          d.legal = 1'b1;
          case (f3)
            FUNCT3_ADD:  d.op = ALU_ADD;
            FUNCT3_SLL:  d.op = ALU_SLL;
            FUNCT3_SLT:  d.op = ALU_SLT;
            FUNCT3_SLTU: d.op = ALU_SLTU;
            FUNCT3_XOR:  d.op = ALU_XOR;
            FUNCT3_SR:   d.op = ALU_SRL;
            FUNCT3_OR:   d.op = ALU_OR;
            default:     d.op = ALU_AND;
          endcase
        end
        FUNCT7_ALT: begin
          if (f3 == FUNCT3_ADD) begin
            d.legal = 1'b1;
            d.op    = ALU_SUB;
          end else if (f3 == FUNCT3_SR) begin
            d.legal = 1'b1;
            d.op    = ALU_SRA;
          end
        end
`ifdef RTYPE_MUL_EN
        FUNCT7_MULDIV: begin
          if (f3 == FUNCT3_ADD) begin
            d.legal = 1'b1;
            d.op    = ALU_MUL;
          end
        end
`endif
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/rtype_exec_ctrl_if.sv
// Instruction handshake plus regfile read/write ports of rtype_exec_ctrl.
// master = the controller, slave = issue stage / regfile side.
interface rtype_exec_ctrl_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic            rf_rd_en;
  logic [AW-1:0]   rf_rd_addr1;
  logic [AW-1:0]   rf_rd_addr2;
  logic [XLEN-1:0] rf_rd_data1;
  logic [XLEN-1:0] rf_rd_data2;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;

  modport master (
    input  instr_valid, instr, rf_rd_data1, rf_rd_data2,
    output instr_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2,
           rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    output instr_valid, instr, rf_rd_data1, rf_rd_data2,
    input  instr_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2,
           rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/rtype_alu.sv
// Combinational R-type ALU; results wrap at XLEN bits.
// Build option: RTYPE_MUL_EN adds the low-half multiplier for ALU_MUL.
module rtype_alu
  import rtype_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: y = XLEN'(a < b);
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = XLEN'($signed(a) >>> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
`ifdef RTYPE_MUL_EN
      ALU_MUL:  y = a * b;
`endif
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Single-issue R-type sequencer: IDLE -> RD -> EX -> WB, sole master of the regfile ports.
// Build option: RTYPE_MUL_EN (see rtype_pkg / rtype_alu) makes MUL legal.
module rtype_exec_ctrl
  import rtype_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  rtype_exec_ctrl_if.master  bus,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired_cnt
);

  state_t           state_q, state_d;
  logic [ILEN-1:0]  instr_q, instr_d;
  alu_op_t          op_q, op_d;
  logic             bad_q, bad_d;
  logic             instr_ready_q, instr_ready_d;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr1_q, rd_addr1_d;
  logic [AW-1:0]    rd_addr2_q, rd_addr2_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]  wr_data_q, wr_data_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  dec_t             dec;
  logic [XLEN-1:0]  alu_y;

  assign dec = rtype_decode(instr_q);

  // Operands arrive from the registered regfile during EX; the result is flopped into wr_data.
  rtype_alu #(.XLEN(XLEN)) u_alu (
    .op (op_q),
    .a  (bus.rf_rd_data1),
    .b  (bus.rf_rd_data2),
    .y  (alu_y)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    op_d       = op_q;
    bad_d      = bad_q;
    rd_en_d    = 1'b0;
    rd_addr1_d = rd_addr1_q;
    rd_addr2_d = rd_addr2_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.instr_valid && instr_ready_q) begin
          instr_d    = bus.instr;
          rd_en_d    = 1'b1;
          rd_addr1_d = AW'(bus.instr[19:15]);
          rd_addr2_d = AW'(bus.instr[24:20]);
          state_d    = RD;
        end
      end
      RD: begin
        op_d    = dec.op;
        bad_d   = ~dec.legal;
        state_d = EX;
      end
      EX: begin
        state_d = WB;
        if (bad_q) begin
          illegal_d = 1'b1;
        end else begin
          done_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          // x0 is hardwired: retire without a write strobe.
          if (instr_q[11:7] != 5'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = AW'(instr_q[11:7]);
            wr_data_d = alu_y;
          end
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    instr_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      op_q          <= ALU_ADD;
      bad_q         <= 1'b0;
      instr_ready_q <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr1_q    <= '0;
      rd_addr2_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      op_q          <= op_d;
      bad_q         <= bad_d;
      instr_ready_q <= instr_ready_d;
      rd_en_q       <= rd_en_d;
      rd_addr1_q    <= rd_addr1_d;
      rd_addr2_q    <= rd_addr2_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.rf_rd_en    = rd_en_q;
  assign bus.rf_rd_addr1 = rd_addr1_q;
  assign bus.rf_rd_addr2 = rd_addr2_q;
  assign bus.rf_wr_en    = wr_en_q;
  assign bus.rf_wr_addr  = wr_addr_q;
  assign bus.rf_wr_data  = wr_data_q;
  assign done            = done_q;
  assign illegal         = illegal_q;
  assign retired_cnt     = cnt_q;

endmodule
